// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer / deserializer pair.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package serdes_pkg;

    // Frame FSM encoding shared by the serializer and its tests.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Default word width, common to the PISO and the downstream SIPO.
    localparam int SERDES_WIDTH = 4;

    // Ceiling log2 with a floor of 1, so a counter is never zero bits wide.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/piso_tx.sv
// Parallel-in serial-out serializer feeding the SIPO's data_in directly.
// Latency: first bit on serial_out one cycle after the accepting edge; one bit per cycle.
// Backpressure: load_ready only in IDLE or the last bit cycle, giving zero-bubble back-to-back frames.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   load_valid   load_data is valid this cycle
//   load_ready   a word can be accepted this cycle (combinational)
//   load_data    WIDTH-bit parallel word
//   serial_out   registered serial bit stream
//   frame_active high while serial_out carries a frame bit
//   frame_last   high while serial_out carries the last bit of a frame
module piso_tx
    import serdes_pkg::*;
#(
    parameter int WIDTH      = SERDES_WIDTH,
    parameter bit LSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             serial_out,
    output logic             frame_active,
    output logic             frame_last
);

    localparam int            CW       = clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             serial_out_q, serial_out_d;
    logic             frame_active_q, frame_active_d;
    logic             frame_last_q, frame_last_d;

    logic at_last;
    logic xfer;

    always_comb begin
        state_d        = state_q;
        shreg_d        = shreg_q;
        bit_cnt_d      = bit_cnt_q;
        serial_out_d   = IDLE_LEVEL;
        frame_active_d = 1'b0;
        frame_last_d   = 1'b0;

        // bit_cnt tracks the frame cycle currently visible on serial_out.
        at_last    = (state_q == ST_SHIFT) && (bit_cnt_q == CNT_LAST);
        // Gated by rst so nothing is offered while reset is held.
        load_ready = rst && ((state_q == ST_IDLE) || at_last);
        xfer       = load_valid && load_ready;

        if (xfer) begin
            state_d   = ST_SHIFT;
            shreg_d   = load_data;
            bit_cnt_d = '0;
        end else if (state_q == ST_SHIFT) begin
            if (at_last) begin
                state_d   = ST_IDLE;
                shreg_d   = '0;
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + CW'(1);
                if (LSB_FIRST) begin
                    shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                end else begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                end
            end
        end

        // Output end of the next shift register drives the next serial bit,
        // so serial_out and the framing flags stay registered and aligned.
        if (state_d == ST_SHIFT) begin
            serial_out_d   = LSB_FIRST ? shreg_d[0] : shreg_d[WIDTH-1];
            frame_active_d = 1'b1;
            frame_last_d   = (bit_cnt_d == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            shreg_q        <= '0;
            bit_cnt_q      <= '0;
            serial_out_q   <= IDLE_LEVEL;
            frame_active_q <= 1'b0;
            frame_last_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            bit_cnt_q      <= bit_cnt_d;
            serial_out_q   <= serial_out_d;
            frame_active_q <= frame_active_d;
            frame_last_q   <= frame_last_d;
        end
    end

    assign serial_out   = serial_out_q;
    assign frame_active = frame_active_q;
    assign frame_last   = frame_last_q;

endmodule
